uart_char_rx: RTL
=================

Name: uart_char_rx

Overview:
- 8N1 UART receiver feeding the character comparator.
- Deserialises the opponent board's serial line into bytes.
- Presents each valid byte on curr_char for exactly one clock. At all other times curr_char is 8'h00, so the comparator's IDLE state never re-triggers on a stale 'L'/'R'.
- Also reports frame errors for debug LEDs.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit. Fixed at 16; other values are unsupported.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-low (0 = reset). One clock; reset is synchronous and active-low.
- rx  input  1  asynchronous serial line, idle high.
- curr_char  output  8  received byte, valid only while rx_done=1, else 8'h00.
- rx_done  output  1  one-cycle strobe, a good frame completed.
- frame_err  output  1  one-cycle strobe, stop bit sampled low.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - curr_char=8'h00, rx_done=0, frame_err=0, busy=0.
  - State=IDLE; tick and bit counters cleared.
  - Synchroniser flops preset to 1.
  - Reset during any state aborts the frame with no strobe.
- Synchroniser: 2 flops on rx; all logic uses the second flop (rx_s). rx_s lags rx by 2 clks.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*16), truncated. DIV >= 2 is required.
  - Free-running counter 0..DIV-1; tick=1 for one clk when the counter equals DIV-1.
  - Start-bit alignment error is therefore at most 1 tick (1/16 bit).
- FSM states IDLE, START, DATA, STOP, RECOVER; 4-bit tick_cnt and 3-bit bit_cnt.
- IDLE: on rx_s=0, go to START and clear tick_cnt.
- START: count ticks. At tick_cnt=7 (mid start bit) sample rx_s:
  - 0: go to DATA, clear tick_cnt and bit_cnt.
  - 1: glitch; return to IDLE with no strobe.
- DATA:
  - On every 16th tick (tick_cnt wraps 15->0), sample rx_s into shift register bit bit_cnt. LSB first.
  - After bit 7, go to STOP.
- STOP: on the 16th tick sample rx_s.
  - 1: next clk rx_done=1 and curr_char=assembled byte; go to IDLE.
  - 0: next clk frame_err=1 and curr_char stays 8'h00; go to RECOVER.
- RECOVER: wait for rx_s=1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Strobes:
  - rx_done and frame_err are never high together.
  - Each is high for exactly 1 clk; curr_char returns to 8'h00 the following clk.
- Latency: strobe appears 1 clk after the clk carrying the stop-bit sampling tick.
- Back-to-back frames:
  - A start bit may follow immediately after the mid-stop sample.
  - IDLE re-detects a low rx_s on the cycle after the strobe; no byte is lost with 1 stop bit.
- A byte of 8'h00 is valid: rx_done=1 while curr_char=8'h00. Downstream must qualify by rx_done if it needs NULs.
- busy=1 in START/DATA/STOP/RECOVER.

Test Plan:
All scenarios use CLK_HZ=1600000, BAUD=10000, so DIV=10 and 1 bit = 160 clks.
1. Reset: hold rst=0 for 5 clks with rx toggling -> all outputs 0 and busy=0 throughout; after release, idle rx=1 produces no strobes for 2000 clks.
2. Single frame 0x4C ('L'): serial bits 0,0,0,1,1,0,0,1,0,1 -> exactly one rx_done pulse with curr_char=8'h4C, within 1 clk of the expected time (about 1520+/-10 clks after the start edge); curr_char=8'h00 before and after.
3. Back-to-back 'R' then 'L' with no idle gap -> two rx_done pulses carrying 8'h52 then 8'h4C, about 1600 clks apart; frame_err never asserted.
4. Glitch rejection: rx low for 40 clks (4 ticks), then high -> FSM returns to IDLE, no rx_done, no frame_err, busy drops within 80 clks.
5. Framing error: send 0x52 with stop bit 0, hold rx low 500 clks, then release -> exactly one frame_err pulse, no rx_done, curr_char stays 8'h00; busy stays 1 until rx returns high; a following valid 0x4C is received correctly.
6. Reset mid-frame: assert rst=0 during bit 4 of a frame, release, then send 0x4C -> no strobe for the aborted frame; the new frame yields rx_done with curr_char=8'h4C.

Source files
------------

// File: rtl/uart_char_rx_if.sv
// Signal bundle between the UART character receiver and its consumer.
// rx_done / frame_err are single-cycle strobes with no back-pressure (no ready);
// curr_char carries data only while rx_done=1 and is 8'h00 in every other cycle.
interface uart_char_rx_if;
  logic       rx;
  logic [7:0] curr_char;
  logic       rx_done;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  modport slave (
    input  rx,
    output curr_char,
    output rx_done,
    output frame_err,
    output busy,
    output dbg_state
  );

  modport master (
    output rx,
    input  curr_char,
    input  rx_done,
    input  frame_err,
    input  busy,
    input  dbg_state
  );
endinterface

// File: rtl/uart_char_rx.sv
// 8N1 UART receiver with 16x oversampling; emits each good byte for one clock
// and reports stop-bit framing errors as a one-clock strobe.
module uart_char_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_char_rx_if.slave bus
);

  // DIV must be at least 2 for the tick counter to make sense.
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  state_t           r_state;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_char;
  logic             r_done;
  logic             r_err;

  state_t           w_state_nx;
  logic [3:0]       w_tick_nx;
  logic [2:0]       w_bit_nx;
  logic [7:0]       w_shift_nx;
  logic [7:0]       w_char_nx;
  logic             w_done_nx;
  logic             w_err_nx;

  // Synchroniser flops preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_char     <= 8'h00;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tick_cnt <= w_tick_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_char     <= w_char_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = r_tick_cnt;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_char_nx  = 8'h00;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nx = S_START;
          w_tick_nx  = 4'd0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd7) begin
            if (!r_rx_s) begin
              w_state_nx = S_DATA;
              w_tick_nx  = 4'd0;
              w_bit_nx   = 3'd0;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_tick_nx = r_tick_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        // Sampling on the 15->0 wrap keeps every sample mid-bit after the start alignment.
        if (w_tick) begin
          w_tick_nx = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_shift_nx[r_bit_cnt] = r_rx_s;
            if (r_bit_cnt == 3'd7) begin
              w_state_nx = S_STOP;
            end else begin
              w_bit_nx = r_bit_cnt + 3'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_tick_nx = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            if (r_rx_s) begin
              w_done_nx  = 1'b1;
              w_char_nx  = r_shift;
              w_state_nx = S_IDLE;
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = S_RECOVER;
            end
          end
        end
      end
      S_RECOVER: begin
        if (r_rx_s) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.curr_char = r_char;
  assign bus.rx_done   = r_done;
  assign bus.frame_err = r_err;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dbg_state = r_state;

endmodule
